// File: rtl/alu_seq16_if.sv
// Shared types for the 16-bit ALU sequencer and the req/gnt bus between the
// sequencer (master) and the shared 8-bit ALU (slave).
package alu_seq16_pkg;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 16;
  localparam int unsigned FW = 4;

  typedef enum logic [3:0] {
    alu_NOP  = 4'd0,
    alu_ADD  = 4'd1,
    alu_ADC  = 4'd2,
    alu_SUB  = 4'd3,
    alu_SBC  = 4'd4,
    alu_INCL = 4'd5,
    alu_DECL = 4'd6
  } alu_op_t;

  localparam logic [1:0] CMD_ADD16  = 2'b00;
  localparam logic [1:0] CMD_ADDSPE = 2'b01;
  localparam logic [1:0] CMD_INC16  = 2'b10;
  localparam logic [1:0] CMD_RSVD   = 2'b11;

  typedef struct packed {
    alu_op_t       op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [FW-1:0] flags;
  } alu_drive_t;
endpackage

interface alu_seq16_if;
  logic                                alu_req;
  logic                                alu_gnt;
  alu_seq16_pkg::alu_op_t              alu_op;
  logic [alu_seq16_pkg::DW-1:0]        alu_a;
  logic [alu_seq16_pkg::DW-1:0]        alu_b;
  logic [alu_seq16_pkg::FW-1:0]        alu_flags;
  logic [alu_seq16_pkg::DW-1:0]        alu_res;
  logic [alu_seq16_pkg::FW-1:0]        alu_nflags;
  logic [alu_seq16_pkg::AW-1:0]        alu_addr;

  modport master (
    output alu_req, alu_op, alu_a, alu_b, alu_flags,
    input  alu_gnt, alu_res, alu_nflags, alu_addr
  );

  modport slave (
    input  alu_req, alu_op, alu_a, alu_b, alu_flags,
    output alu_gnt, alu_res, alu_nflags, alu_addr
  );
endinterface

// File: rtl/alu_seq16.sv
// Sequencer that borrows the shared 8-bit ALU to run 16-bit ADD HL,rr,
// SP+e8 and 16-bit INC as low/high byte passes, assembling result and flags.
module alu_seq16
  import alu_seq16_pkg::*;
(
  input  logic          clk,
  input  logic          rst_b,
  input  logic          start,
  input  logic [1:0]    cmd,
  input  logic [AW-1:0] opnd_x,
  input  logic [AW-1:0] opnd_y,
  input  logic [FW-1:0] flags_in,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] result,
  output logic [FW-1:0] flags_out,
  alu_seq16_if.master   alu
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LO   = 3'd1,
    S_HI   = 3'd2,
    S_INC  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    cmd_q, cmd_d;
  logic [AW-1:0] x_q, x_d;
  logic [AW-1:0] y_q, y_d;
  logic [FW-1:0] fl_q, fl_d;
  logic [DW-1:0] lo_res_q, lo_res_d;
  logic          lo_h_q, lo_h_d;
  logic          lo_c_q, lo_c_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [AW-1:0] result_q, result_d;
  logic [FW-1:0] flags_q, flags_d;
  logic          req_q, req_d;
  alu_drive_t    drv_q, drv_d;
  logic          step;
  logic          unused_nflags;

  assign step          = req_q & alu.alu_gnt;
  assign unused_nflags = ^alu.alu_nflags[FW-1:2];

  // Next state, captures, and the ALU drive for the state being entered.
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    x_d      = x_q;
    y_d      = y_q;
    fl_d     = fl_q;
    lo_res_d = lo_res_q;
    lo_h_d   = lo_h_q;
    lo_c_d   = lo_c_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    result_d = result_q;
    flags_d  = flags_q;
    req_d    = 1'b0;
    drv_d    = '0;
    drv_d.op = alu_NOP;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cmd_d  = cmd;
          x_d    = opnd_x;
          y_d    = opnd_y;
          fl_d   = flags_in;
          busy_d = 1'b1;
          err_d  = 1'b0;
          case (cmd)
            CMD_ADD16, CMD_ADDSPE: state_d = S_LO;
            CMD_INC16:             state_d = S_INC;
            default: begin
              state_d  = S_DONE;
              done_d   = 1'b1;
              err_d    = 1'b1;
              result_d = opnd_x;
              flags_d  = flags_in;
            end
          endcase
        end
      end
      S_LO: begin
        if (step) begin
          lo_res_d = alu.alu_res;
          lo_h_d   = alu.alu_nflags[1];
          lo_c_d   = alu.alu_nflags[0];
          state_d  = S_HI;
        end
      end
      S_HI: begin
        if (step) begin
          result_d = {alu.alu_res, lo_res_q};
          // SP+e8 reports the byte-level carries; ADD16 keeps Z and uses bits 11/15
          if (cmd_q == CMD_ADDSPE) flags_d = {2'b00, lo_h_q, lo_c_q};
          else                     flags_d = {fl_q[3], 1'b0, alu.alu_nflags[1:0]};
          done_d   = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_INC: begin
        if (step) begin
          result_d = alu.alu_addr;
          flags_d  = fl_q;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_LO: begin
        req_d    = 1'b1;
        drv_d.op = alu_ADD;
        drv_d.a  = x_d[DW-1:0];
        drv_d.b  = y_d[DW-1:0];
      end
      S_HI: begin
        req_d       = 1'b1;
        drv_d.op    = alu_ADC;
        drv_d.a     = x_d[AW-1:DW];
        drv_d.b     = (cmd_d == CMD_ADDSPE) ? {DW{y_d[DW-1]}} : y_d[AW-1:DW];
        drv_d.flags = {3'b000, lo_c_d};
      end
      S_INC: begin
        req_d    = 1'b1;
        drv_d.op = alu_INCL;
        drv_d.a  = x_d[AW-1:DW];
        drv_d.b  = x_d[DW-1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q  <= S_IDLE;
      cmd_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      fl_q     <= '0;
      lo_res_q <= '0;
      lo_h_q   <= 1'b0;
      lo_c_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
      req_q    <= 1'b0;
      drv_q    <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      x_q      <= x_d;
      y_q      <= y_d;
      fl_q     <= fl_d;
      lo_res_q <= lo_res_d;
      lo_h_q   <= lo_h_d;
      lo_c_q   <= lo_c_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      req_q    <= req_d;
      drv_q    <= drv_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign result        = result_q;
  assign flags_out     = flags_q;
  assign alu.alu_req   = req_q;
  assign alu.alu_op    = drv_q.op;
  assign alu.alu_a     = drv_q.a;
  assign alu.alu_b     = drv_q.b;
  assign alu.alu_flags = drv_q.flags;

endmodule

// File: tb/tb_alu_seq16.sv
// Bench for alu_seq16: behavioural 8-bit ALU on the bus, 16-bit reference
// model feeding a scoreboard queue, one task per scenario.
module tb_alu_seq16;
  import alu_seq16_pkg::*;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  fl;
    logic        err;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  cmd = 2'b00;
  logic [15:0] opnd_x = '0;
  logic [15:0] opnd_y = '0;
  logic [3:0]  flags_in = '0;
  logic        busy, done, err;
  logic [15:0] result;
  logic [3:0]  flags_out;
  logic        gnt = 1'b1;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  alu_seq16_if alu_bus ();

  alu_seq16 dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .start     (start),
    .cmd       (cmd),
    .opnd_x    (opnd_x),
    .opnd_y    (opnd_y),
    .flags_in  (flags_in),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .result    (result),
    .flags_out (flags_out),
    .alu       (alu_bus)
  );

  always #5 clk = ~clk;

  assign alu_bus.alu_gnt = gnt;

  // Behavioural shared ALU (combinational)
  logic [8:0] s9;
  logic [4:0] s5;
  logic       cin;
  always_comb begin
    s9 = '0;
    s5 = '0;
    cin = 1'b0;
    alu_bus.alu_res    = '0;
    alu_bus.alu_nflags = '0;
    alu_bus.alu_addr   = '0;
    case (alu_bus.alu_op)
      alu_ADD, alu_ADC: begin
        cin = (alu_bus.alu_op == alu_ADC) ? alu_bus.alu_flags[0] : 1'b0;
        s9 = {1'b0, alu_bus.alu_a} + {1'b0, alu_bus.alu_b} + 9'(cin);
        s5 = {1'b0, alu_bus.alu_a[3:0]} + {1'b0, alu_bus.alu_b[3:0]} + 5'(cin);
        alu_bus.alu_res    = s9[7:0];
        alu_bus.alu_nflags = {(s9[7:0] == 8'h00), 1'b0, s5[4], s9[8]};
      end
      alu_INCL: alu_bus.alu_addr = {alu_bus.alu_a, alu_bus.alu_b} + 16'd1;
      default: ;
    endcase
  end

  // 16-bit reference: whole-word arithmetic, not byte passes
  function automatic exp_t model(input logic [1:0] c, input logic [15:0] x,
                                 input logic [15:0] y, input logic [3:0] f);
    exp_t m;
    logic [16:0] s;
    logic [12:0] h12;
    logic [8:0]  c8;
    logic [4:0]  h4;
    m.err = 1'b0;
    case (c)
      2'b00: begin
        s   = {1'b0, x} + {1'b0, y};
        h12 = {1'b0, x[11:0]} + {1'b0, y[11:0]};
        m.res = s[15:0];
        m.fl  = {f[3], 1'b0, h12[12], s[16]};
        m.lat = 3;
      end
      2'b01: begin
        h4 = {1'b0, x[3:0]} + {1'b0, y[3:0]};
        c8 = {1'b0, x[7:0]} + {1'b0, y[7:0]};
        m.res = x + {{8{y[7]}}, y[7:0]};
        m.fl  = {2'b00, h4[4], c8[8]};
        m.lat = 3;
      end
      2'b10: begin
        m.res = x + 16'd1;
        m.fl  = f;
        m.lat = 2;
      end
      default: begin
        m.res = x;
        m.fl  = f;
        m.err = 1'b1;
        m.lat = 1;
      end
    endcase
    return m;
  endfunction

  // Drive one start pulse at a negedge; returns at the cycle-1 sample point
  task automatic launch(input logic [1:0] c, input logic [15:0] x,
                        input logic [15:0] y, input logic [3:0] f);
    cmd = c; opnd_x = x; opnd_y = y; flags_in = f; start = 1'b1;
    sb.push_back(model(c, x, y, f));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int c0, output int cyc);
    cyc = c0;
    while (done !== 1'b1 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, err, alu_bus.alu_req} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl got %b exp 0000", {busy, done, err, alu_bus.alu_req});
    end
    checks++;
    if (result !== 16'h0000 || flags_out !== 4'h0) begin
      errors++; $display("FAIL reset_data got %h/%h exp 0000/0", result, flags_out);
    end
    checks++;
    if (alu_bus.alu_op !== alu_NOP || alu_bus.alu_a !== 8'h00 || alu_bus.alu_b !== 8'h00 ||
        alu_bus.alu_flags !== 4'h0) begin
      errors++; $display("FAIL reset_drive got op %0d a %h b %h f %h exp NOP 00 00 0",
                         alu_bus.alu_op, alu_bus.alu_a, alu_bus.alu_b, alu_bus.alu_flags);
    end
    rst_b = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add16();
    logic [15:0] tx [3] = '{16'h0FFF, 16'hFFFF, 16'h1234};
    logic [15:0] ty [3] = '{16'h0001, 16'h0001, 16'h0F0F};
    logic [3:0]  tf [3] = '{4'h8, 4'h0, 4'hF};
    exp_t e;
    int cyc;
    for (int i = 0; i < 3; i++) begin
      launch(2'b00, tx[i], ty[i], tf[i]);
      wait_done(1, cyc);
      e = sb.pop_front();
      checks++;
      if (cyc !== e.lat) begin errors++; $display("FAIL add16_lat[%0d] got %0d exp %0d", i, cyc, e.lat); end
      checks++;
      if (result !== e.res || flags_out !== e.fl || err !== e.err) begin
        errors++; $display("FAIL add16_out[%0d] got %h/%b/%b exp %h/%b/%b", i, result, flags_out, err, e.res, e.fl, e.err);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || result !== e.res) begin
        errors++; $display("FAIL add16_after[%0d] got done %b busy %b res %h exp 0 0 %h", i, done, busy, result, e.res);
      end
    end
  endtask

  task automatic test_addspe();
    logic [15:0] tx [3] = '{16'hFFF8, 16'h0000, 16'h1000};
    logic [15:0] ty [3] = '{16'h0008, 16'h00FF, 16'hAB80};
    logic [3:0]  tf [3] = '{4'h0, 4'hF, 4'h8};
    exp_t e;
    int cyc;
    for (int i = 0; i < 3; i++) begin
      launch(2'b01, tx[i], ty[i], tf[i]);
      wait_done(1, cyc);
      e = sb.pop_front();
      checks++;
      if (cyc !== e.lat) begin errors++; $display("FAIL addspe_lat[%0d] got %0d exp %0d", i, cyc, e.lat); end
      checks++;
      if (result !== e.res || flags_out !== e.fl || err !== e.err) begin
        errors++; $display("FAIL addspe_out[%0d] got %h/%b/%b exp %h/%b/%b", i, result, flags_out, err, e.res, e.fl, e.err);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_inc16();
    exp_t e;
    int cyc;
    launch(2'b10, 16'hFFFF, 16'h0000, 4'h5);
    checks++;
    if (alu_bus.alu_op !== alu_INCL || alu_bus.alu_req !== 1'b1 ||
        alu_bus.alu_a !== 8'hFF || alu_bus.alu_b !== 8'hFF) begin
      errors++; $display("FAIL inc_drive got op %0d req %b a %h b %h exp INCL 1 ff ff",
                         alu_bus.alu_op, alu_bus.alu_req, alu_bus.alu_a, alu_bus.alu_b);
    end
    wait_done(1, cyc);
    e = sb.pop_front();
    checks++;
    if (cyc !== 2) begin errors++; $display("FAIL inc_lat got %0d exp 2", cyc); end
    checks++;
    if (result !== 16'h0000 || flags_out !== 4'h5 || err !== 1'b0 || result !== e.res) begin
      errors++; $display("FAIL inc_out got %h/%b/%b exp %h/%b/0", result, flags_out, err, e.res, e.fl);
    end
    @(negedge clk);
  endtask

  task automatic test_reserved();
    exp_t e;
    int cyc;
    launch(2'b11, 16'hABCD, 16'h1111, 4'h6);
    wait_done(1, cyc);
    e = sb.pop_front();
    checks++;
    if (cyc !== 1) begin errors++; $display("FAIL rsvd_lat got %0d exp 1", cyc); end
    checks++;
    if (result !== 16'hABCD || flags_out !== 4'h6 || err !== 1'b1 || alu_bus.alu_req !== 1'b0) begin
      errors++; $display("FAIL rsvd_out got %h/%b/%b req %b exp abcd/0110/1 req 0", result, flags_out, err, alu_bus.alu_req);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || err !== 1'b1) begin
      errors++; $display("FAIL rsvd_hold got done %b busy %b err %b exp 0 0 1", done, busy, err);
    end
    launch(2'b10, 16'h00FF, 16'h0000, 4'h0);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL rsvd_err_clear got %b exp 0", err); end
    wait_done(1, cyc);
    e = sb.pop_front();
    checks++;
    if (result !== e.res || flags_out !== e.fl || err !== e.err) begin
      errors++; $display("FAIL rsvd_next got %h/%b/%b exp %h/%b/%b", result, flags_out, err, e.res, e.fl, e.err);
    end
    @(negedge clk);
  endtask

  task automatic test_gnt_stall();
    exp_t e;
    int cyc;
    int extra;
    alu_op_t op0;
    logic [7:0] a0, b0;
    logic [3:0] f0;
    gnt = 1'b1;
    launch(2'b00, 16'h0FFF, 16'h0001, 4'h8);
    @(negedge clk);
    gnt = 1'b0;
    op0 = alu_bus.alu_op; a0 = alu_bus.alu_a; b0 = alu_bus.alu_b; f0 = alu_bus.alu_flags;
    checks++;
    if (op0 !== alu_ADC || a0 !== 8'h0F || b0 !== 8'h00 || f0 !== 4'h1) begin
      errors++; $display("FAIL stall_hi_drive got op %0d a %h b %h f %h exp ADC 0f 00 1", op0, a0, b0, f0);
    end
    cmd = 2'b10; opnd_x = 16'h5555; start = 1'b1;
    for (int k = 3; k <= 5; k++) begin
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (alu_bus.alu_op !== op0 || alu_bus.alu_a !== a0 || alu_bus.alu_b !== b0 ||
          alu_bus.alu_flags !== f0 || alu_bus.alu_req !== 1'b1 || done !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL stall_hold[%0d] got op %0d a %h b %h req %b done %b exp held, req 1, done 0",
                           k, alu_bus.alu_op, alu_bus.alu_a, alu_bus.alu_b, alu_bus.alu_req, done);
      end
    end
    gnt = 1'b1;
    wait_done(5, cyc);
    e = sb.pop_front();
    checks++;
    if (cyc !== 6) begin errors++; $display("FAIL stall_lat got %0d exp 6", cyc); end
    checks++;
    if (result !== e.res || flags_out !== e.fl) begin
      errors++; $display("FAIL stall_out got %h/%b exp %h/%b", result, flags_out, e.res, e.fl);
    end
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL stall_ignored_start got %0d busy/done cycles exp 0", extra); end
  endtask

  task automatic test_reset_mid();
    int seen;
    launch(2'b00, 16'h1234, 16'h1111, 4'h0);
    @(negedge clk);
    checks++;
    if (alu_bus.alu_op !== alu_ADC || busy !== 1'b1) begin
      errors++; $display("FAIL rmid_in_hi got op %0d busy %b exp ADC 1", alu_bus.alu_op, busy);
    end
    rst_b = 1'b0;
    void'(sb.pop_back());
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || alu_bus.alu_req !== 1'b0 || result !== 16'h0000 ||
        alu_bus.alu_op !== alu_NOP) begin
      errors++; $display("FAIL rmid_async got busy %b done %b req %b res %h op %0d exp 0 0 0 0000 NOP",
                         busy, done, alu_bus.alu_req, result, alu_bus.alu_op);
    end
    @(negedge clk);
    rst_b = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL rmid_no_done got %0d active cycles exp 0", seen); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int cyc;
    logic [1:0] c;
    for (int i = 0; i < 24; i++) begin
      c = 2'($urandom_range(0, 3));
      launch(c, 16'($urandom), 16'($urandom), 4'($urandom));
      cyc = 1;
      while (done !== 1'b1 && cyc < 200) begin
        gnt = 1'($urandom_range(0, 1));
        @(negedge clk);
        cyc++;
      end
      gnt = 1'b1;
      e = sb.pop_front();
      checks++;
      if (done !== 1'b1) begin errors++; $display("FAIL b2b_timeout[%0d] got no done exp done", i); end
      checks++;
      if (result !== e.res || flags_out !== e.fl || err !== e.err) begin
        errors++; $display("FAIL b2b_out[%0d] cmd %0d got %h/%b/%b exp %h/%b/%b", i, c, result, flags_out, err, e.res, e.fl, e.err);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_add16();
    test_addspe();
    test_inc16();
    test_reserved();
    test_gnt_stall();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no completion exp finish");
    $fatal(1, "watchdog");
  end

endmodule
